// File: rtl/lsu.sv
// lsu: load/store unit for the execute/memory stage.
// Runs one outstanding request/ack transaction on the data-memory bus,
// builds byte strobes and lane-replicated store data, and returns
// sign/zero-extended load data. Holds the core with `stall` while busy.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses skip
// the bus and report `misaligned`); when undefined, low address bits are
// forced aligned for the access size.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  loadops,
  input  logic [1:0]  storeops,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] NO_LOAD = 3'b111;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          done_q, done_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misaligned_q, misaligned_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    ld_op_q, ld_op_d;
  logic [1:0]    ld_off_q, ld_off_d;

  logic        accept;
  logic        noop;
  logic        trap;
  logic [1:0]  sz;       // 0 byte, 1 half, 2 word
  logic [1:0]  off;      // aligned byte offset within the word
  logic [3:0]  strb;
  logic [31:0] wrep;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  assign accept = op_valid && (memwrite || loadops != NO_LOAD);
  assign noop   = memwrite && (storeops == 2'd0);

  // Decode access size, lane offset, strobes and replicated store data
  always_comb begin
    sz = 2'd2;
    if (memwrite) begin
      case (storeops)
        2'd1:    sz = 2'd0;
        2'd2:    sz = 2'd1;
        default: sz = 2'd2;
      endcase
    end else begin
      case (loadops[1:0])
        2'd0:    sz = 2'd0;
        2'd1:    sz = 2'd1;
        default: sz = 2'd2;
      endcase
    end
    case (sz)
      2'd0: begin
        off  = addr[1:0];
        strb = 4'b0001 << addr[1:0];
        wrep = {4{wdata[7:0]}};
      end
      2'd1: begin
        off  = {addr[1], 1'b0};
        strb = addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        off  = 2'b00;
        strb = 4'b1111;
        wrep = wdata;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    trap = !noop && ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    lane = mem_rdata >> {ld_off_q, 3'b000};
    case (ld_op_q[1:0])
      2'd0:    ld_ext = {{24{!ld_op_q[2] && lane[7]}}, lane[7:0]};
      2'd1:    ld_ext = {{16{!ld_op_q[2] && lane[15]}}, lane[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    bus_err_d    = bus_err_q;
    cnt_d        = cnt_q;
    is_load_d    = is_load_q;
    ld_op_d      = ld_op_q;
    ld_off_d     = ld_off_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d        = '0;
          misaligned_d = 1'b0;
          bus_err_d    = 1'b0;
          mem_addr_d   = {addr[31:2], 2'b00};
          is_load_d    = !memwrite;
          ld_op_d      = loadops;
          ld_off_d     = off;
          mem_we_d     = memwrite;
          mem_wstrb_d  = memwrite ? strb : 4'b0000;
          mem_wdata_d  = memwrite ? wrep : 32'h0;
          if (noop || trap) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            mem_req_d    = 1'b0;
            misaligned_d = trap;
            if (trap) rdata_d = 32'h0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          // an ack on the expiry cycle still completes normally
          state_d   = S_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          if (is_load_q) rdata_d = ld_ext;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // DONE lasts one cycle and ignores op_valid
        state_d      = S_IDLE;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      done_q       <= 1'b0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      ld_op_q      <= 3'b000;
      ld_off_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      ld_op_q      <= ld_op_d;
      ld_off_q     <= ld_off_d;
    end
  end

  assign stall      = (state_q == S_IDLE && accept) || (state_q == S_REQ);
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. Main instance uses the default
// timeout; a second instance with TIMEOUT=4 covers bus-error aborts.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0, op_valid4 = 1'b0;
  logic [2:0]  loadops = 3'b111;
  logic [1:0]  storeops = 2'd0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        mem_ack = 1'b0, mem_ack4 = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        stall, done, misaligned, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        stall4, done4, misaligned4, bus_err4, mem_req4, mem_we4;
  logic [31:0] rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  mem_wstrb4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .loadops(loadops),
    .storeops(storeops), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .op_valid(op_valid4), .loadops(loadops),
    .storeops(storeops), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .stall(stall4), .done(done4), .rdata(rdata4), .misaligned(misaligned4),
    .bus_err(bus_err4), .mem_req(mem_req4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wstrb(mem_wstrb4), .mem_wdata(mem_wdata4),
    .mem_ack(mem_ack4), .mem_rdata(mem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int acc_size(input bit we, input logic [1:0] so, input logic [2:0] lo);
    if (we) return (so == 2'd1) ? 1 : (so == 2'd2) ? 2 : 4;
    return (lo[1:0] == 2'd0) ? 1 : (lo[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int eff_off(input logic [31:0] a, input int sz);
    return (int'(a % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input int sz);
    int m;
    m = ((1 << sz) - 1) << eff_off(a, sz);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int sz);
    if (sz == 1) return wd[7:0] * 32'h01010101;
    if (sz == 2) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] lo, input logic [31:0] a, input logic [31:0] w);
    int sz;
    longint unsigned v, m;
    sz = acc_size(1'b0, 2'd0, lo);
    v  = 64'(w) >> (8 * eff_off(a, sz));
    m  = (64'd1 << (8 * sz)) - 1;
    v  = v & m;
    if (!lo[2] && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~m;
    return v[31:0];
  endfunction

  // One access on the main instance. Starts and ends just after a posedge
  // with the unit idle. dly = REQ cycles without ack before the ack cycle.
  task automatic do_access(input bit we, input logic [1:0] so, input logic [2:0] lo,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly, input string nm);
    int sz;
    bit mis, nobus;
    logic [68:0] exp_bus, obs_bus;
    sz    = acc_size(we, so, lo);
    mis   = (a % sz) != 0;
    nobus = (we && so == 2'd0) || (TRAP && mis);
    exp_bus = {1'b1, we, a & 32'hFFFF_FFFC, we ? exp_strb(a, sz) : 4'b0000,
               we ? exp_wdata(wd, sz) : 32'h0};
    memwrite = we; storeops = so; loadops = lo; addr = a; wdata = wd;
    op_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL %s accept-stall: got %b expected 1", nm, stall); end
    @(posedge clk); #1;
    op_valid = 1'b0; addr = $urandom; wdata = $urandom;
    if (nobus) begin
      @(negedge clk);
      checks++;
      if ({done, mem_req, stall, misaligned} !== {1'b1, 1'b0, 1'b0, TRAP && mis && !(we && so == 2'd0)}) begin
        errors++;
        $display("FAIL %s nobus done/req/stall/mis: got %b expected %b", nm,
                 {done, mem_req, stall, misaligned}, {1'b1, 1'b0, 1'b0, TRAP && mis && !(we && so == 2'd0)});
      end
      if (TRAP && mis && !(we && so == 2'd0)) begin
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL %s trap-rdata: got %h expected 0", nm, rdata); end
      end
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i <= dly; i++) begin
        if (i == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
        @(negedge clk);
        obs_bus = {mem_req, mem_we, mem_addr, mem_wstrb, we ? mem_wdata : 32'h0};
        checks++;
        if (obs_bus !== exp_bus || stall !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s req-cycle%0d bus: got %h stall=%b done=%b expected %h stall=1 done=0",
                   nm, i, obs_bus, stall, done, exp_bus);
        end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({done, mem_req, stall, bus_err, misaligned} !== 5'b10000) begin
        errors++;
        $display("FAIL %s done-cycle: got done/req/stall/err/mis=%b expected 10000", nm,
                 {done, mem_req, stall, bus_err, misaligned});
      end
      if (!we) begin
        checks++;
        if (rdata !== exp_load(lo, a, rd)) begin
          errors++; $display("FAIL %s rdata: got %h expected %h", nm, rdata, exp_load(lo, a, rd));
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done-pulse-width: got %b expected 0", nm, done); end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({stall, done, rdata, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset main: got nonzero outputs rdata=%h addr=%h req=%b", rdata, mem_addr, mem_req);
    end
    checks++;
    if ({stall4, done4, rdata4, misaligned4, bus_err4, mem_req4, mem_we4, mem_addr4, mem_wstrb4, mem_wdata4} !== '0) begin
      errors++; $display("FAIL reset t4: got nonzero outputs rdata=%h addr=%h req=%b", rdata4, mem_addr4, mem_req4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_byte();
    do_access(1'b1, 2'd1, 3'b111, 32'h1003, 32'h0000_00A5, 32'h0, 0, "sb_1003");
    do_access(1'b1, 2'd2, 3'b000, 32'h1002, 32'hDEAD_BEEF, 32'h0, 1, "sh_1002");
    do_access(1'b1, 2'd0, 3'b111, 32'h1004, 32'h1234_5678, 32'h0, 0, "store_noop");
  endtask

  task automatic test_load_ext();
    do_access(1'b0, 2'd0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 0, "lb_2001");
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_const: got %h expected ffffff80", rdata); end
    do_access(1'b0, 2'd0, 3'b100, 32'h2001, 32'h0, 32'h0000_8000, 0, "lbu_2001");
    checks++;
    if (rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_const: got %h expected 00000080", rdata); end
    do_access(1'b0, 2'd0, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 2, "lh_2002");
    do_access(1'b0, 2'd0, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 0, "lhu_2002");
  endtask

  task automatic test_lw_delay();
    do_access(1'b0, 2'd0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 5, "lw_delay5");
  endtask

  task automatic test_misalign();
    do_access(1'b1, 2'd3, 3'b111, 32'h3002, 32'h1122_3344, 32'h0, 0, "sw_3002");
    do_access(1'b0, 2'd0, 3'b001, 32'h3001, 32'h0, 32'hA5B6_C7D8, 0, "lh_3001");
  endtask

  task automatic test_timeout();
    loadops = 3'b010; memwrite = 1'b0; storeops = 2'd0; addr = 32'h40;
    op_valid4 = 1'b1;
    @(posedge clk); #1; op_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req4, done4, stall4} !== 3'b101) begin
        errors++; $display("FAIL timeout req%0d: got req/done/stall=%b expected 101", i, {mem_req4, done4, stall4});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({mem_req4, done4, bus_err4, rdata4} !== {3'b011, 32'h0}) begin
      errors++; $display("FAIL timeout abort: got req/done/err=%b rdata=%h expected 011 0",
                         {mem_req4, done4, bus_err4}, rdata4);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    op_valid4 = 1'b1;
    @(posedge clk); #1; op_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack4 = 1'b1; mem_rdata = 32'h1234_5678; end
      @(negedge clk);
      checks++;
      if (mem_req4 !== 1'b1) begin errors++; $display("FAIL timeout2 req%0d: got %b expected 1", i, mem_req4); end
      @(posedge clk); #1;
    end
    mem_ack4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done4, bus_err4, rdata4} !== {2'b10, 32'h1234_5678}) begin
      errors++; $display("FAIL ack_on_expiry: got done/err=%b rdata=%h expected 10 12345678",
                         {done4, bus_err4}, rdata4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    loadops = 3'b010; memwrite = 1'b0; addr = 32'h500; op_valid = 1'b1;
    @(posedge clk); #1; op_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, done, stall} !== 3'b000) begin
      errors++; $display("FAIL rst_mid: got req/done/stall=%b expected 000", {mem_req, done, stall});
    end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, done, rdata} !== {2'b00, 32'h0}) begin
        errors++; $display("FAIL stray_ack%0d: got req/done=%b rdata=%h expected 00 0", i, {mem_req, done}, rdata);
      end
      @(posedge clk); #1;
    end
    do_access(1'b0, 2'd0, 3'b010, 32'h600, 32'h0, 32'h0BAD_F00D, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    loadops = 3'b010; memwrite = 1'b0; addr = 32'h100; op_valid = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_ack = 1'b0; addr = 32'h204;
    @(negedge clk);
    checks++;
    if ({done, stall, mem_req, rdata} !== {3'b100, 32'h1111_1111}) begin
      errors++; $display("FAIL b2b first: got done/stall/req=%b rdata=%h", {done, stall, mem_req}, rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done, stall, mem_req} !== 3'b010) begin
      errors++; $display("FAIL b2b accept: got done/stall/req=%b expected 010", {done, stall, mem_req});
    end
    @(posedge clk); #1; op_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h204}) begin
      errors++; $display("FAIL b2b second req: got req=%b addr=%h expected 1 00000204", mem_req, mem_addr);
    end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, rdata} !== {1'b1, 32'h2222_2222}) begin
      errors++; $display("FAIL b2b second done: got done=%b rdata=%h", done, rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] ltab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit we;
    logic [1:0] so;
    logic [2:0] lo;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom % 2);
      so = 2'($urandom % 4);
      lo = we ? 3'($urandom % 8) : ltab[$urandom % 5];
      do_access(we, so, lo, $urandom, $urandom, $urandom, int'($urandom % 4), "random");
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_store_byte();
    test_load_ext();
    test_lw_delay();
    test_misalign();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
